// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the comparator arbiter: FSM encodings and operand width.
package cmp_arbiter_pkg;

   localparam int unsigned CMP_W = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCmp  = 2'd1,
      StResp = 2'd2
   } cmp_arb_state_e;

endpackage

// File: rtl/signed_cmp4.sv
// Pure combinational signed 4-bit magnitude comparator.
module signed_cmp4
   import cmp_arbiter_pkg::*;
(
   input  logic [CMP_W-1:0] a_i,
   input  logic [CMP_W-1:0] b_i,
   output logic             agb_o,
   output logic             eq_o,
   output logic             alb_o
);

   // Two's complement compare; exactly one output is high.
   always_comb begin
      agb_o = ($signed(a_i) > $signed(b_i));
      eq_o  = (a_i == b_i);
      alb_o = ($signed(a_i) < $signed(b_i));
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Arbitrates NREQ requesters onto one shared signed 4-bit comparator.
// Round-robin by default; define CMP_ARB_FIXED_PRIO_EN for fixed priority
// (lowest asserted index wins, no rotating pointer).
module cmp_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [4*NREQ-1:0]    a_in,
   input  logic [4*NREQ-1:0]    b_in,
   output logic [NREQ-1:0]      ack,
   output logic                 agb,
   output logic                 eq,
   output logic                 alb,
   output logic [IDW-1:0]       gnt_id,
   output logic                 busy
);
   import cmp_arbiter_pkg::*;

   cmp_arb_state_e   state_q;
   logic [CMP_W-1:0] op_a_q, op_b_q;
   logic             agb_q, eq_q, alb_q;
   logic [IDW-1:0]   gnt_q;
   logic [NREQ-1:0]  ack_q;
   logic             grant_d;
   logic [IDW-1:0]   gnt_d;
   logic [IDW-1:0]   idx;
   logic             cmp_agb, cmp_eq, cmp_alb;

`ifdef CMP_ARB_FIXED_PRIO_EN
   // Fixed priority: lowest asserted index wins.
   always_comb begin
      grant_d = 1'b0;
      gnt_d   = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'(k);
         if (!grant_d && req[idx]) begin
            grant_d = 1'b1;
            gnt_d   = idx;
         end
      end
   end
`else
   logic [IDW-1:0] rr_q;

   // Round-robin: search from rr_q upward, wrapping modulo NREQ.
   always_comb begin
      grant_d = 1'b0;
      gnt_d   = '0;
      idx     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(rr_q) + k) % NREQ);
         if (!grant_d && req[idx]) begin
            grant_d = 1'b1;
            gnt_d   = idx;
         end
      end
   end

   // Pointer advances past the requester just served, once its ack is out.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= '0;
      end else if (state_q == StResp) begin
         rr_q <= (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
      end
   end
`endif

   signed_cmp4 u_cmp (
      .a_i   (op_a_q),
      .b_i   (op_b_q),
      .agb_o (cmp_agb),
      .eq_o  (cmp_eq),
      .alb_o (cmp_alb)
   );

   // Grant / compare / respond sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         op_a_q  <= '0;
         op_b_q  <= '0;
         agb_q   <= 1'b0;
         eq_q    <= 1'b0;
         alb_q   <= 1'b0;
         gnt_q   <= '0;
         ack_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               ack_q <= '0;
               if (grant_d) begin
                  // Operands are captured only here; later input changes are ignored.
                  op_a_q  <= a_in[gnt_d*CMP_W +: CMP_W];
                  op_b_q  <= b_in[gnt_d*CMP_W +: CMP_W];
                  gnt_q   <= gnt_d;
                  state_q <= StCmp;
               end
            end
            StCmp: begin
               agb_q   <= cmp_agb;
               eq_q    <= cmp_eq;
               alb_q   <= cmp_alb;
               ack_q   <= NREQ'(1) << gnt_q;
               state_q <= StResp;
            end
            StResp: begin
               ack_q   <= '0;
               state_q <= StIdle;
            end
            default: begin
               ack_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ack    = ack_q;
   assign agb    = agb_q;
   assign eq     = eq_q;
   assign alb    = alb_q;
   assign gnt_id = gnt_q;
   assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter (NREQ=4); honours CMP_ARB_FIXED_PRIO_EN.
module tb_cmp_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req;
   logic [15:0]     a_in, b_in;
   logic [3:0]      ack;
   logic            agb, eq, alb;
   logic [1:0]      gnt_id;
   logic            busy;

   int n_chk  = 0;
   int n_pass = 0;

   cmp_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .a_in   (a_in),
      .b_in   (b_in),
      .ack    (ack),
      .agb    (agb),
      .eq     (eq),
      .alb    (alb),
      .gnt_id (gnt_id),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  ack;
      logic [2:0]  flags;  // {agb, eq, alb}
      logic [1:0]  gnt;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until ack is seen or the limit is reached; edges counts clock edges taken.
   task automatic wait_ack(input int limit, output int edges);
      edges = 0;
      do begin
         step();
         edges++;
      end while (ack == 4'b0 && edges < limit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int seen;
      logic [3:0] exp_id[4];
      logic [2:0] rr_flags[4];

      //            req      a         b         ack      {agb,eq,alb} gnt
      vecs[0] = '{4'b0001, 16'h0007, 16'h0008, 4'b0001, 3'b100, 2'd0}; // 7 > -8
      vecs[1] = '{4'b0010, 16'h0080, 16'h0070, 4'b0010, 3'b001, 2'd1}; // -8 < 7
      vecs[2] = '{4'b0100, 16'h0F00, 16'h0F00, 4'b0100, 3'b010, 2'd2}; // -1 == -1
      vecs[3] = '{4'b1000, 16'h0000, 16'hF000, 4'b1000, 3'b100, 2'd3}; // 0 > -1
      vecs[4] = '{4'b0001, 16'h000E, 16'h0001, 4'b0001, 3'b001, 2'd0}; // -2 < 1
      vecs[5] = '{4'b1000, 16'h3000, 16'h5000, 4'b1000, 3'b001, 2'd3}; // 3 < 5

      rst  = 1'b1;
      req  = '0;
      a_in = '0;
      b_in = '0;
      repeat (3) step();
      check("rst_ack", ack, 4'b0);
      check("rst_flags", {agb, eq, alb}, 3'b000);
      check("rst_gnt", gnt_id, 2'd0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      step();
      check("idle_ack", ack, 4'b0);

      // Single requests: ack two edges after the req cycle, i.e. third cycle.
      foreach (vecs[i]) begin
         req  = vecs[i].req;
         a_in = vecs[i].a;
         b_in = vecs[i].b;
         wait_ack(8, e);
         check($sformatf("v%0d_lat", i), e, 2);
         check($sformatf("v%0d_ack", i), ack, vecs[i].ack);
         check($sformatf("v%0d_flags", i), {agb, eq, alb}, vecs[i].flags);
         check($sformatf("v%0d_gnt", i), gnt_id, vecs[i].gnt);
         check($sformatf("v%0d_busy", i), busy, 1'b1);
         req = '0;
         step();
         check($sformatf("v%0d_ack_off", i), ack, 4'b0);
         check($sformatf("v%0d_idle", i), busy, 1'b0);
      end

      // All four request at once; requester i posts a=i, b=1.
      rr_flags[0] = 3'b001;
      rr_flags[1] = 3'b010;
      rr_flags[2] = 3'b100;
      rr_flags[3] = 3'b100;
      req  = 4'b1111;
      a_in = 16'h3210;
      b_in = 16'h1111;
      for (int i = 0; i < 4; i++) begin
         wait_ack(8, e);
         check($sformatf("rr%0d_spacing", i), e, (i == 0) ? 2 : 3);
         check($sformatf("rr%0d_ack", i), ack, 4'b0001 << i);
         check($sformatf("rr%0d_gnt", i), gnt_id, i);
         check($sformatf("rr%0d_flags", i), {agb, eq, alb}, rr_flags[i]);
         req[i] = 1'b0;
      end
      step();
      check("rr_idle", busy, 1'b0);

      // Requesters 0 and 3 both keep req high across several operations.
`ifdef CMP_ARB_FIXED_PRIO_EN
      exp_id = '{4'd0, 4'd0, 4'd0, 4'd0};
`else
      exp_id = '{4'd0, 4'd3, 4'd0, 4'd3};
`endif
      req  = 4'b1001;
      a_in = 16'h2005;
      b_in = 16'h1001;
      for (int i = 0; i < 4; i++) begin
         wait_ack(8, e);
         check($sformatf("prio%0d_spacing", i), e, (i == 0) ? 2 : 3);
         check($sformatf("prio%0d_ack", i), ack, 4'b0001 << exp_id[i]);
         check($sformatf("prio%0d_gnt", i), gnt_id, exp_id[i]);
         check($sformatf("prio%0d_agb", i), {agb, eq, alb}, 3'b100);
      end
      req = '0;
      step();
      check("prio_idle", busy, 1'b0);

      // Operand change and req drop after the grant edge.
      req  = 4'b0100;
      a_in = 16'h0D00;
      b_in = 16'h0D00;
      step();
      check("opchg_busy", busy, 1'b1);
      a_in = 16'h0500;
      req  = '0;
      wait_ack(8, e);
      check("opchg_lat", e, 1);
      check("opchg_ack", ack, 4'b0100);
      check("opchg_flags", {agb, eq, alb}, 3'b010);
      check("opchg_gnt", gnt_id, 2'd2);
      step();

      // Reset while the comparator stage is pending.
      req  = 4'b0010;
      a_in = 16'h0010;
      b_in = 16'h0020;
      step();
      check("mid_gnt", gnt_id, 2'd1);
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      req = '0;
      step();
      check("mid_rst_ack", ack, 4'b0);
      check("mid_rst_flags", {agb, eq, alb}, 3'b000);
      check("mid_rst_gnt", gnt_id, 2'd0);
      check("mid_rst_busy", busy, 1'b0);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ack != 4'b0) seen++;
      end
      check("mid_no_ack", seen, 0);

      req  = 4'b0100;
      a_in = 16'h0400;
      b_in = 16'h0C00;  // 4 > -4
      wait_ack(8, e);
      check("post_lat", e, 2);
      check("post_ack", ack, 4'b0100);
      check("post_flags", {agb, eq, alb}, 3'b100);
      check("post_gnt", gnt_id, 2'd2);
      req = '0;
      step();
      check("post_idle", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
